line_window_cache: RTL and testbench
====================================

LINE_WINDOW_CACHE -- requirements
Module: line_window_cache

Interface
REQ-001 Parameter IMG_W, default 32: image width in pixels, >= K.
REQ-002 Parameter IMG_H, default 32: image height in rows, >= K.
REQ-003 Parameter K, default 3: window size; odd, 3..7.
REQ-004 Parameter DW, default 8: pixel width in bits.
REQ-005 clk  input  1: single clock; all logic on its rising edge.
REQ-006 rst  input  1: asynchronous, active-low reset.
REQ-007 frame_start  input  1: marks the current data_load pixel as pixel (0,0) of a new frame.
REQ-008 data_load  input  1: data_i is valid this cycle.
REQ-009 data_i  input  DW: incoming pixel, raster order.
REQ-010 window  output  K*K x DW: packed array; element r*K+c holds pixel (row-r, col-c) relative to the newest pixel.
REQ-011 window_valid  output  1: window covers K x K in-frame pixels.
REQ-012 row_o, col_o  output  clog2(IMG_H), clog2(IMG_W): coordinates of the newest pixel in window[0].
REQ-013 frame_done  output  1: one-cycle pulse when the last frame pixel has been accepted.

Function
REQ-014 FSM states IDLE and RUN; reset state is IDLE.
REQ-015 IDLE: data_load without frame_start is ignored, with no state change; data_load with frame_start accepts the pixel as (0,0) and moves to RUN.
REQ-016 RUN: each data_load accepts one pixel; no data_load means every register holds (stall).
REQ-017 Accepted pixel updates window, row_o, col_o, window_valid and frame_done on the same rising edge; latency is 1 cycle.
REQ-018 K-1 line buffers, each IMG_W deep, are chained. Buffer 1 takes data_i; buffer j takes the output of buffer j-1.
REQ-019 On accept, window row 0 shifts in data_i. Window row r>0 shifts in the output of buffer r. Column c moves to column c+1.
REQ-020 col counter wraps IMG_W-1 -> 0 and increments row; row counter does not wrap within a frame.
REQ-021 window_valid = 1 after accept iff row >= K-1 and col >= K-1; otherwise 0, and window contents are don't-care.
REQ-022 window_valid holds its value during stalls.
REQ-023 frame_done pulses after accept of pixel (IMG_H-1, IMG_W-1); the FSM returns to IDLE on that edge.
REQ-024 frame_start with data_load while in RUN restarts the frame: the pixel becomes (0,0) and window_valid is forced 0.
REQ-025 Line buffer contents are not cleared on restart.
REQ-026 frame_start without data_load is ignored in both states.
REQ-027 The last pixel of a frame with frame_start on the same cycle is treated as the new frame's (0,0); frame_done does not pulse.

Reset
REQ-028 rst low asynchronously clears window, line buffers, counters, window_valid and frame_done to 0, and sets the FSM to IDLE.
REQ-029 rst low mid-frame discards the frame; after release, the block waits for frame_start.
REQ-030 Reset release is synchronised by the integrator; the block requires no minimum pulse width beyond one clock.

Structure
REQ-031 The shared package lwc_pkg holds the FSM state enum (IDLE, RUN) and the default constants IMG_W, IMG_H, K, DW.
REQ-032 One sub-module, line_buffer (parameters DEPTH, DW; shift on enable), is instantiated K-1 times.
REQ-033 Counter widths use $clog2; no latches and no combinational path from inputs to outputs.

Verification (IMG_W=8, IMG_H=6, K=3, DW=8, pixel value = row*8+col)
REQ-034 Reset: rst low mid-stream -> window, row_o, col_o, window_valid and frame_done read 0 immediately, before any clock edge.
REQ-035 Full frame, no stalls: 48 loads with frame_start on the first.
- First window_valid after load 18: window[0]=18, window[4]=9, window[8]=0.
- Exactly 24 valid cycles.
- frame_done pulses once, after pixel 47.
REQ-036 Random data_load gaps (~30% idle) -> sequence of valid windows identical to REQ-035; outputs are stable during gaps.
REQ-037 IDLE gating: 5 data_load pulses without frame_start after reset -> col_o=0, row_o=0, window_valid=0, FSM stays IDLE.
REQ-038 Mid-frame restart: frame_start with load at pixel 20 -> row_o=0, col_o=0, window_valid=0; next valid after 18 further loads.
REQ-039 Parameter sweep: K=5, IMG_W=16 full frame -> first valid at pixel (4,4), window[24]=pixel (0,0), and (16-4)*(IMG_H-4) valid cycles.

Source files
------------

// File: rtl/lwc_pkg.sv
// Shared definitions for the line window cache.
//
// Contents:
//   lwc_state_t   - frame sequencing FSM states (IDLE, RUN)
//   DEF_IMG_W     - default image width in pixels
//   DEF_IMG_H     - default image height in rows
//   DEF_K         - default window size (odd, 3..7)
//   DEF_DW        - default pixel width in bits
package lwc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lwc_state_t;

    localparam int DEF_IMG_W = 32;
    localparam int DEF_IMG_H = 32;
    localparam int DEF_K     = 3;
    localparam int DEF_DW    = 8;

endpackage

// File: rtl/line_buffer.sv
// One image line of delay: a DEPTH-deep shift register that advances only
// when en is high, so dout is the pixel written DEPTH enables ago.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset, clears the storage
//   en    - shift enable (one accepted pixel)
//   din   - pixel shifted in
//   dout  - oldest stored pixel
module line_buffer #(
    parameter int DEPTH = 32,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DEPTH-1:0][DW-1:0] mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '0;
        end else if (en) begin
            mem <= {mem[DEPTH-2:0], din};
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/line_window_cache.sv
// Sliding K x K pixel window over a raster-order pixel stream.
//
// K-1 chained line buffers provide the pixels directly above the incoming
// one; a K x K register array shifts one column per accepted pixel.
//
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-low reset
//   frame_start  - current data_load pixel is (0,0) of a new frame
//   data_load    - data_i valid this cycle
//   data_i       - incoming pixel
//   window       - element r*K+c = pixel (row-r, col-c) from the newest pixel
//   window_valid - window covers K x K in-frame pixels
//   row_o, col_o - coordinates of the newest pixel (window[0])
//   frame_done   - one-cycle pulse after the last frame pixel is accepted
module line_window_cache
    import lwc_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int K     = DEF_K,
    parameter int DW    = DEF_DW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_start,
    input  logic                       data_load,
    input  logic [DW-1:0]              data_i,
    output logic [K*K-1:0][DW-1:0]     window,
    output logic                       window_valid,
    output logic [$clog2(IMG_H)-1:0]   row_o,
    output logic [$clog2(IMG_W)-1:0]   col_o,
    output logic                       frame_done
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);

    lwc_state_t state, state_nxt;

    logic                  accept;
    logic                  last_px;
    logic [RW-1:0]         row_nxt;
    logic [CW-1:0]         col_nxt;
    logic [K-2:0][DW-1:0]  lb_out;
    logic [K-1:0][DW-1:0]  row_src;

    // In IDLE only a frame_start pixel is taken; in RUN every load is.
    assign accept = data_load && (frame_start || (state == RUN));

    // Coordinates the pixel being offered would take if accepted.
    always_comb begin
        row_nxt = row_o;
        col_nxt = col_o;
        if (frame_start) begin
            row_nxt = '0;
            col_nxt = '0;
        end else if (col_o == COL_LAST) begin
            row_nxt = row_o + RW'(1);
            col_nxt = '0;
        end else begin
            col_nxt = col_o + CW'(1);
        end
    end

    // A frame_start on the final pixel turns it into the next frame's (0,0).
    assign last_px = !frame_start && (row_nxt == ROW_LAST) && (col_nxt == COL_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (data_load && frame_start) state_nxt = RUN;
            RUN:     if (data_load && last_px)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Line buffer chain: buffer j delays buffer j-1 by one more image line.
    for (genvar j = 0; j < K-1; j++) begin : g_lb
        logic [DW-1:0] lb_in;
        if (j == 0) begin : g_first
            assign lb_in = data_i;
        end else begin : g_chain
            assign lb_in = lb_out[j-1];
        end
        line_buffer #(
            .DEPTH (IMG_W),
            .DW    (DW)
        ) u_lb (
            .clk  (clk),
            .rst  (rst),
            .en   (accept),
            .din  (lb_in),
            .dout (lb_out[j])
        );
    end

    assign row_src[0] = data_i;
    for (genvar r = 1; r < K; r++) begin : g_src
        assign row_src[r] = lb_out[r-1];
    end

    // Window stage: column 0 of each row takes the new column, older columns
    // move one place right.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            window <= '0;
        end else if (accept) begin
            for (int r = 0; r < K; r++) begin
                window[r*K] <= row_src[r];
                for (int c = 1; c < K; c++) begin
                    window[r*K+c] <= window[r*K+c-1];
                end
            end
        end
    end

    // Position and status registered alongside the window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_o        <= '0;
            col_o        <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                row_o        <= row_nxt;
                col_o        <= col_nxt;
                window_valid <= (row_nxt >= ROW_MIN) && (col_nxt >= COL_MIN);
                frame_done   <= last_px;
            end
        end
    end

endmodule

// File: tb/tb_line_window_cache.sv
module tb_line_window_cache;

    localparam int AW = 8,  AH = 6, AK = 3;
    localparam int BW = 16, BH = 6, BK = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic                  a_fs, a_ld;
    logic [7:0]            a_d;
    logic [AK*AK-1:0][7:0] a_win;
    logic                  a_vld, a_done;
    logic [2:0]            a_row, a_col;

    logic                  b_fs, b_ld;
    logic [7:0]            b_d;
    logic [BK*BK-1:0][7:0] b_win;
    logic                  b_vld, b_done;
    logic [2:0]            b_row;
    logic [3:0]            b_col;

    line_window_cache #(.IMG_W(AW), .IMG_H(AH), .K(AK), .DW(8)) dut_a (
        .clk(clk), .rst(rst), .frame_start(a_fs), .data_load(a_ld), .data_i(a_d),
        .window(a_win), .window_valid(a_vld), .row_o(a_row), .col_o(a_col),
        .frame_done(a_done));

    line_window_cache #(.IMG_W(BW), .IMG_H(BH), .K(BK), .DW(8)) dut_b (
        .clk(clk), .rst(rst), .frame_start(b_fs), .data_load(b_ld), .data_i(b_d),
        .window(b_win), .window_valid(b_vld), .row_o(b_row), .col_o(b_col),
        .frame_done(b_done));

    typedef struct packed {
        logic             id;
        logic             acc;
        logic [7:0]       row;
        logic [7:0]       col;
        logic             vld;
        logic             done;
        logic [24:0][7:0] win;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int n_valid, n_done;
    bit got_first;
    int first_row, first_col;
    logic [24:0][7:0] first_w;

    // Reference model: the current frame as a 2-D image plus a cursor.
    int m_run[2], m_r[2], m_c[2];
    bit m_v[2];
    int img[2][6][16];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic model_step(input int id, input bit fs, input bit ld,
                              input logic [7:0] d, output exp_t e);
        int w, h, k;
        w = (id == 1) ? BW : AW;
        h = (id == 1) ? BH : AH;
        k = (id == 1) ? BK : AK;
        e = '0;
        e.id = (id == 1);
        if (ld && (m_run[id] != 0 || fs)) begin
            e.acc = 1'b1;
            if (fs) begin
                m_r[id] = 0;
                m_c[id] = 0;
            end else if (m_c[id] == w - 1) begin
                m_r[id]++;
                m_c[id] = 0;
            end else begin
                m_c[id]++;
            end
            img[id][m_r[id]][m_c[id]] = int'(d);
            m_v[id] = (m_r[id] >= k - 1) && (m_c[id] >= k - 1);
            e.done = !fs && (m_r[id] == h - 1) && (m_c[id] == w - 1);
            m_run[id] = e.done ? 0 : 1;
        end
        e.row = 8'(m_r[id]);
        e.col = 8'(m_c[id]);
        e.vld = m_v[id];
        if (m_v[id]) begin
            for (int rr = 0; rr < k; rr++)
                for (int cc = 0; cc < k; cc++)
                    e.win[rr*k+cc] = 8'(img[id][m_r[id]-rr][m_c[id]-cc]);
        end
    endtask

    task automatic drive(input int id, input bit fs, input bit ld, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        a_fs = (id == 0) && fs;
        a_ld = (id == 0) && ld;
        a_d  = d;
        b_fs = (id == 1) && fs;
        b_ld = (id == 1) && ld;
        b_d  = d;
        model_step(id, fs, ld, d, e);
        q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (q.size() > 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        a_ld = 1'b0; a_fs = 1'b0; b_ld = 1'b0; b_fs = 1'b0;
    endtask

    task automatic clear_stats();
        n_valid = 0;
        n_done = 0;
        got_first = 1'b0;
        first_row = -1;
        first_col = -1;
        first_w = '0;
    endtask

    // Monitor: one expected record per driven cycle, compared after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.id == 1'b0) begin
                chk("a_row", int'(a_row), int'(e.row));
                chk("a_col", int'(a_col), int'(e.col));
                chk("a_valid", int'(a_vld), int'(e.vld));
                chk("a_done", int'(a_done), int'(e.done));
                if (e.vld)
                    for (int i = 0; i < AK*AK; i++)
                        chk($sformatf("a_win[%0d]", i), int'(a_win[i]), int'(e.win[i]));
                if (e.acc && a_vld) begin
                    n_valid++;
                    if (!got_first) begin
                        got_first = 1'b1;
                        first_row = int'(a_row);
                        first_col = int'(a_col);
                        for (int i = 0; i < AK*AK; i++) first_w[i] = a_win[i];
                    end
                end
                if (a_done) n_done++;
            end else begin
                chk("b_row", int'(b_row), int'(e.row));
                chk("b_col", int'(b_col), int'(e.col));
                chk("b_valid", int'(b_vld), int'(e.vld));
                chk("b_done", int'(b_done), int'(e.done));
                if (e.vld)
                    for (int i = 0; i < BK*BK; i++)
                        chk($sformatf("b_win[%0d]", i), int'(b_win[i]), int'(e.win[i]));
                if (e.acc && b_vld) begin
                    n_valid++;
                    if (!got_first) begin
                        got_first = 1'b1;
                        first_row = int'(b_row);
                        first_col = int'(b_col);
                        for (int i = 0; i < BK*BK; i++) first_w[i] = b_win[i];
                    end
                end
                if (b_done) n_done++;
            end
        end
    end

    task automatic check_first_a(input string tag);
        chk({tag, "_valid_cnt"}, n_valid, 24);
        chk({tag, "_done_cnt"}, n_done, 1);
        chk({tag, "_first_row"}, first_row, 2);
        chk({tag, "_first_col"}, first_col, 2);
        chk({tag, "_first_w0"}, int'(first_w[0]), 18);
        chk({tag, "_first_w4"}, int'(first_w[4]), 9);
        chk({tag, "_first_w8"}, int'(first_w[8]), 0);
    endtask

    initial begin
        int pix;
        rst = 1'b0;
        a_fs = 1'b0; a_ld = 1'b0; a_d = '0;
        b_fs = 1'b0; b_ld = 1'b0; b_d = '0;
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_r[i] = 0; m_c[i] = 0; m_v[i] = 1'b0;
        end
        clear_stats();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_row", int'(a_row), 0);
        chk("rst_a_col", int'(a_col), 0);
        chk("rst_a_valid", int'(a_vld), 0);
        chk("rst_a_done", int'(a_done), 0);
        chk("rst_a_win_zero", int'(a_win == '0), 1);
        @(negedge clk);
        rst = 1'b1;

        // Loads without frame_start are ignored in IDLE.
        repeat (5) drive(0, 1'b0, 1'b1, 8'($urandom));
        drain();
        chk("idle_row", int'(a_row), 0);
        chk("idle_col", int'(a_col), 0);
        chk("idle_valid", int'(a_vld), 0);

        // Full frame, no stalls; pixel value = raster index.
        clear_stats();
        for (int i = 0; i < AW*AH; i++) drive(0, i == 0, 1'b1, 8'(i));
        drain();
        check_first_a("full");

        // After the frame the block is back in IDLE: plain loads change nothing.
        repeat (2) drive(0, 1'b0, 1'b1, 8'($urandom));
        drain();
        chk("post_done_row", int'(a_row), AH - 1);
        chk("post_done_col", int'(a_col), AW - 1);

        // Same frame with random idle gaps, some carrying a lone frame_start.
        clear_stats();
        pix = 0;
        while (pix < AW*AH) begin
            if ($urandom_range(0, 99) < 30) begin
                drive(0, 1'($urandom_range(0, 1)), 1'b0, 8'($urandom));
            end else begin
                drive(0, pix == 0, 1'b1, 8'(pix));
                pix++;
            end
        end
        drain();
        check_first_a("gaps");

        // Random-data frame restarted at pixel 20.
        for (int i = 0; i < 20; i++) drive(0, i == 0, 1'b1, 8'($urandom));
        drive(0, 1'b1, 1'b1, 8'($urandom));
        drain();
        chk("restart_row", int'(a_row), 0);
        chk("restart_col", int'(a_col), 0);
        chk("restart_valid", int'(a_vld), 0);
        repeat (17) drive(0, 1'b0, 1'b1, 8'($urandom));
        drain();
        chk("restart_17_valid", int'(a_vld), 0);
        drive(0, 1'b0, 1'b1, 8'($urandom));
        drain();
        chk("restart_18_valid", int'(a_vld), 1);

        // Final pixel arriving with frame_start opens a new frame instead.
        clear_stats();
        repeat (28) drive(0, 1'b0, 1'b1, 8'($urandom));
        drive(0, 1'b1, 1'b1, 8'($urandom));
        drain();
        chk("last_fs_done_cnt", n_done, 0);
        chk("last_fs_row", int'(a_row), 0);
        chk("last_fs_col", int'(a_col), 0);

        // Asynchronous reset in the middle of a frame.
        repeat (10) drive(0, 1'b0, 1'b1, 8'($urandom));
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_row", int'(a_row), 0);
        chk("async_rst_col", int'(a_col), 0);
        chk("async_rst_valid", int'(a_vld), 0);
        chk("async_rst_done", int'(a_done), 0);
        chk("async_rst_win_zero", int'(a_win == '0), 1);
        m_run[0] = 0; m_r[0] = 0; m_c[0] = 0; m_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) drive(0, 1'b0, 1'b1, 8'($urandom));
        drain();
        chk("post_rst_row", int'(a_row), 0);
        chk("post_rst_col", int'(a_col), 0);

        // Wider window on a wider image, with gaps.
        clear_stats();
        pix = 0;
        while (pix < BW*BH) begin
            if ($urandom_range(0, 99) < 20) begin
                drive(1, 1'b0, 1'b0, 8'($urandom));
            end else begin
                drive(1, pix == 0, 1'b1, 8'(pix));
                pix++;
            end
        end
        drain();
        chk("k5_valid_cnt", n_valid, (16 - 4) * (BH - 4));
        chk("k5_done_cnt", n_done, 1);
        chk("k5_first_row", first_row, 4);
        chk("k5_first_col", first_col, 4);
        chk("k5_first_w0", int'(first_w[0]), 4*16 + 4);
        chk("k5_first_w24", int'(first_w[24]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
